// File: rtl/rgb2hsv_seq_pkg.sv
// Shared definitions for the sequential RGB-to-HSV converter: FSM encoding,
// hue/saturation scale constants and divider step count.
package rgb2hsv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MINMAX,
    DIV_S,
    DIV_H,
    DONE
  } state_t;

  localparam logic [7:0] HUE_SECTOR = 8'd43;
  localparam logic [7:0] G_BASE     = 8'd85;
  localparam logic [7:0] B_BASE     = 8'd171;
  localparam logic [7:0] S_SCALE    = 8'd255;

  // Quotient bits still to produce after the start cycle has made the first one.
  localparam logic [2:0] DIV_STEPS_AFTER_START = 3'd7;

endpackage

// File: rtl/hsv_seq_div8.sv
// Restoring divider, 16-bit dividend by 8-bit divisor, 8-bit quotient, one bit per cycle.
// The start cycle already produces the MSB, so a divide occupies exactly 8 edges.
module hsv_seq_div8
  import rgb2hsv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  input  logic [7:0]  i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_quotient
);

  logic [7:0] r_rem;
  logic [7:0] r_low;
  logic [7:0] r_quo;
  logic [7:0] r_divisor;
  logic [2:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_zero;

  logic [7:0] w_remIn;
  logic [7:0] w_lowIn;
  logic [7:0] w_quoIn;
  logic [7:0] w_divisor;
  logic [8:0] w_trial;
  logic [8:0] w_sub;
  logic       w_ge;

  // The caller guarantees dividend[15:8] < divisor, so the remainder fits 8 bits.
  always_comb begin
    w_remIn   = i_start ? i_dividend[15:8] : r_rem;
    w_lowIn   = i_start ? i_dividend[7:0]  : r_low;
    w_quoIn   = i_start ? 8'd0             : r_quo;
    w_divisor = i_start ? i_divisor        : r_divisor;
    w_trial   = {w_remIn, w_lowIn[7]};
    w_ge      = (w_trial >= {1'b0, w_divisor});
    w_sub     = w_trial - {1'b0, w_divisor};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= 8'd0;
      r_low     <= 8'd0;
      r_quo     <= 8'd0;
      r_divisor <= 8'd0;
      r_cnt     <= 3'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_rem <= w_ge ? w_sub[7:0] : w_trial[7:0];
        r_low <= {w_lowIn[6:0], 1'b0};
        r_quo <= {w_quoIn[6:0], w_ge};
      end
      if (i_start) begin
        r_divisor <= i_divisor;
        r_zero    <= (i_divisor == 8'd0);
        r_cnt     <= DIV_STEPS_AFTER_START;
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_zero ? 8'd0 : r_quo;

endmodule

// File: rtl/rgb2hsv_seq.sv
// One-pixel-at-a-time RGB to packed HSV converter with valid/ready on both sides,
// sharing a single iterative divider between saturation and hue.
module rgb2hsv_seq
  import rgb2hsv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] tRGB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] tHSV
);

  state_t     r_state;
  logic [7:0] r_red;
  logic [7:0] r_grn;
  logic [7:0] r_blu;
  logic [7:0] r_max;
  logic [7:0] r_delta;
  logic [7:0] r_absDiff;
  logic [7:0] r_base;
  logic [7:0] r_sat;
  logic       r_neg;
  logic       r_divStart;

  logic [7:0]  w_max;
  logic [7:0]  w_min;
  logic [7:0]  w_lo;
  logic [7:0]  w_diffA;
  logic [7:0]  w_diffB;
  logic [7:0]  w_base;
  logic        w_neg;
  logic [7:0]  w_absDiff;
  logic        w_useH;
  logic [15:0] w_sProd;
  logic [15:0] w_hProd;
  logic [15:0] w_dividend;
  logic [7:0]  w_divisor;
  logic        w_divStart;
  logic        w_divBusy;
  logic        w_divDone;
  logic [7:0]  w_quot;
  logic [7:0]  w_hue;

  // Max channel with tie priority R > G > B; diff operands follow the chosen sector.
  always_comb begin
    if (r_red >= r_grn && r_red >= r_blu) begin
      w_max   = r_red;
      w_diffA = r_grn;
      w_diffB = r_blu;
      w_base  = 8'd0;
    end else if (r_grn >= r_blu) begin
      w_max   = r_grn;
      w_diffA = r_blu;
      w_diffB = r_red;
      w_base  = G_BASE;
    end else begin
      w_max   = r_blu;
      w_diffA = r_red;
      w_diffB = r_grn;
      w_base  = B_BASE;
    end
    w_lo      = (r_red < r_grn) ? r_red : r_grn;
    w_min     = (w_lo < r_blu) ? w_lo : r_blu;
    w_neg     = (w_diffA < w_diffB);
    w_absDiff = w_neg ? (w_diffB - w_diffA) : (w_diffA - w_diffB);
  end

  // The hue divide is launched on the same edge the saturation quotient is captured.
  always_comb begin
    w_useH     = (r_state == DIV_S) && w_divDone;
    w_sProd    = {8'd0, S_SCALE} * {8'd0, r_delta};
    w_hProd    = {8'd0, HUE_SECTOR} * {8'd0, r_absDiff};
    w_dividend = w_useH ? w_hProd : w_sProd;
    w_divisor  = w_useH ? r_delta : r_max;
    w_divStart = !w_divBusy && (r_divStart || w_useH);
    w_hue      = (r_delta == 8'd0) ? 8'd0
               : (r_neg ? (r_base - w_quot) : (r_base + w_quot));
  end

  hsv_seq_div8 u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_divStart),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_divBusy),
    .o_done     (w_divDone),
    .o_quotient (w_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      tHSV       <= 24'd0;
      r_red      <= 8'd0;
      r_grn      <= 8'd0;
      r_blu      <= 8'd0;
      r_max      <= 8'd0;
      r_delta    <= 8'd0;
      r_absDiff  <= 8'd0;
      r_base     <= 8'd0;
      r_sat      <= 8'd0;
      r_neg      <= 1'b0;
      r_divStart <= 1'b0;
    end else begin
      r_divStart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_red    <= tRGB[23:16];
            r_grn    <= tRGB[15:8];
            r_blu    <= tRGB[7:0];
            in_ready <= 1'b0;
            r_state  <= MINMAX;
          end
        end
        MINMAX: begin
          r_max      <= w_max;
          r_delta    <= w_max - w_min;
          r_absDiff  <= w_absDiff;
          r_neg      <= w_neg;
          r_base     <= w_base;
          r_divStart <= 1'b1;
          r_state    <= DIV_S;
        end
        DIV_S: begin
          if (w_divDone) begin
            r_sat   <= w_quot;
            r_state <= DIV_H;
          end
        end
        DIV_H: begin
          if (w_divDone) begin
            tHSV      <= {w_hue, r_sat, r_max};
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Directed bench for rgb2hsv_seq: expected HSV words are queued at accept time
// and compared when out_valid appears, together with latency and handshake checks.
module tb_rgb2hsv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] tRGB = 24'd0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] tHSV;

  int          nChecks = 0;
  int          nFail = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  logic [23:0] expQ[$];

  rgb2hsv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tRGB      (tRGB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tHSV      (tHSV)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    nChecks++;
    assert (obs === expVal) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expVal);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [23:0] pix, input logic [23:0] expVal);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      stepCycle();
      waited++;
    end
    checkVal({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tRGB     = pix;
    stepCycle();
    acceptCyc = cyc;
    in_valid  = 1'b0;
    expQ.push_back(expVal);
    checkVal({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
  endtask

  task automatic checkOutput(input string tag);
    int waited = 0;
    logic [23:0] expVal;
    while (out_valid !== 1'b1 && waited < 40) begin
      stepCycle();
      waited++;
    end
    checkVal({tag, " latency"}, 32'(cyc - acceptCyc), 32'd18);
    checkVal({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    if (expQ.size() == 0) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL %s scoreboard: observed no queued entry expected one", tag);
    end else begin
      expVal = expQ.pop_front();
      checkVal({tag, " tHSV"}, 32'(tHSV), 32'(expVal));
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    stepCycle();
    checkVal({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    checkVal({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convertOne(input string tag, input logic [23:0] pix, input logic [23:0] expVal);
    applyStimulus(tag, pix, expVal);
    checkOutput(tag);
    handoff(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) stepCycle();
    checkVal("reset in_ready", 32'(in_ready), 32'd1);
    checkVal("reset out_valid", 32'(out_valid), 32'd0);
    checkVal("reset tHSV", 32'(tHSV), 32'd0);
    reset = 1'b0;
    stepCycle();

    convertOne("red",     24'hFF0000, 24'h00FFFF);
    convertOne("green",   24'h00FF00, 24'h55FFFF);
    convertOne("blue",    24'h0000FF, 24'hABFFFF);
    convertOne("yellow",  24'hFFFF00, 24'h2BFFFF);
    convertOne("magenta", 24'hFF00FF, 24'hD5FFFF);
    convertOne("gray",    24'h808080, 24'h000080);
    convertOne("black",   24'h000000, 24'h000000);
    convertOne("white",   24'hFFFFFF, 24'h0000FF);
    convertOne("c86432",  24'hC86432, 24'h0EBFC8);

    // Downstream stall: result must hold and a waiting pixel must not be taken.
    out_ready = 1'b0;
    applyStimulus("stall", 24'hFFFF00, 24'h2BFFFF);
    checkOutput("stall");
    in_valid = 1'b1;
    tRGB     = 24'h0000FF;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkVal("stall tHSV held", 32'(tHSV), 32'h2BFFFF);
      checkVal("stall out_valid held", 32'(out_valid), 32'd1);
      checkVal("stall in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handoff("stall");
    convertOne("after stall", 24'h0000FF, 24'hABFFFF);

    // Reset while the hue divide is in flight.
    applyStimulus("midreset", 24'h0000FF, 24'hABFFFF);
    repeat (12) stepCycle();
    reset = 1'b1;
    stepCycle();
    checkVal("midreset out_valid", 32'(out_valid), 32'd0);
    checkVal("midreset tHSV", 32'(tHSV), 32'd0);
    checkVal("midreset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    expQ.delete();
    repeat (10) stepCycle();
    checkVal("midreset no stale result", 32'(out_valid), 32'd0);
    convertOne("post reset green", 24'h00FF00, 24'h55FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
